mem_port_arbiter: RTL

Shares one single-port synchronous RAM between the core's instruction fetch (IF stage, PC) and data access (MEM stage, ena_rd/ena_wr/alu_out_ext/dataram_wr).
Serialises the two requests, with data given priority. Drives a pipeline-wide stall while either request is unserved. Holds the returned read data stable until the pipeline advances.
Sits between the pipelined core and the unified memory.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared types and constants for the memory port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Deepest RAM read latency the arbiter's wait counter can cover
  localparam int LAT_MAX = 4;

  // Width of the latency down-counter (holds 0 .. LAT_MAX-1)
  localparam int CNT_W = $clog2(LAT_MAX);

  // Arbiter FSM: wait for a request, strobe the RAM, wait for read data
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Which requester owns the access currently in flight
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one single-port synchronous RAM between instruction fetch
//             and data access. Data wins ties; the pipeline stalls until every
//             live request of the current instruction has been served, and the
//             returned read data is held until the next capture.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          CLOCK,
  input  logic          RST_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Counter reload value: cycles still to wait after the strobe cycle
  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(LAT - 1);

  state_t          r_state;
  state_t          w_next_state;
  owner_t          r_owner;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_we;
  logic [CNT_W-1:0] r_cnt;
  logic            r_d_done;
  logic            r_if_done;
  logic [DW-1:0]   r_if_rdata;
  logic [DW-1:0]   r_d_rdata;

  logic            w_d_pend;
  logic            w_if_pend;
  logic            w_grant_d;
  logic            w_grant_if;
  logic            w_last;

  // A requester is pending until its done flag is set for this instruction
  assign w_d_pend   = (d_rd | d_wr) & ~r_d_done;
  assign w_if_pend  = if_req & ~r_if_done;
  assign stall      = w_d_pend | w_if_pend;

  // Data has priority; fetch is granted only when no data access is pending
  assign w_grant_d  = (r_state == IDLE) & w_d_pend;
  assign w_grant_if = (r_state == IDLE) & ~w_d_pend & w_if_pend;

  // Final wait cycle: RAM read data is valid now
  assign w_last     = (r_state == WAIT) & (r_cnt == '0);

  assign if_rdata   = r_if_rdata;
  assign d_rdata    = r_d_rdata;

  // State register
  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one strobe cycle, then wait out the read latency
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_d | w_grant_if) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (r_cnt == '0) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // RAM strobe outputs; the strobe is suppressed while reset is held
  always_comb begin
    mem_en    = (r_state == ISSUE) & RST_n;
    mem_we    = mem_en & r_we;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
  end

  // Request latch, latency counter, done flags and held read data
  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      r_owner    <= OWN_IF;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_d_done   <= 1'b0;
      r_if_done  <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_grant_d) begin
        r_owner <= OWN_D;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_we    <= d_wr;
      end else if (w_grant_if) begin
        r_owner <= OWN_IF;
        r_addr  <= if_addr;
        r_we    <= 1'b0;
      end

      if (r_state == ISSUE) begin
        r_cnt <= c_CNT_LOAD;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_last && !r_we) begin
        if (r_owner == OWN_D) begin
          r_d_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end

      // The pipeline advances on any unstalled edge, so the next
      // instruction's requests start fresh
      if (!stall) begin
        r_d_done  <= 1'b0;
        r_if_done <= 1'b0;
      end else if (w_last) begin
        if (r_owner == OWN_D) begin
          r_d_done <= 1'b1;
        end else begin
          r_if_done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
